// File: rtl/data_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_arbiter_if
// Brief    : CPU, debug and memory-side bus bundle for data_mem_arbiter.
// Revision : 1.0  initial release
// ============================================================================

`ifndef WRITE_DISABLE
`define WRITE_DISABLE 2'b00
`define WRITE_BYTE    2'b01
`define WRITE_HALF    2'b10
`define WRITE_WORD    2'b11
`define READ_DISABLE  2'b00
`define READ_BYTE     2'b01
`define READ_HALF     2'b10
`define READ_WORD     2'b11
`endif

interface data_mem_arbiter_if #(
    parameter int NB_DEPTH = 8,
    parameter int NB_DATA  = 32
);
    logic [NB_DEPTH-1:0] i_cpu_addr;
    logic [NB_DATA-1:0]  i_cpu_wdata;
    logic [1:0]          i_cpu_we;
    logic [1:0]          i_cpu_re;
    logic [NB_DATA-1:0]  o_cpu_rdata;
    logic                o_cpu_stall;

    logic                i_dbg_req;
    logic [1:0]          i_dbg_op;
    logic [NB_DEPTH-1:0] i_dbg_addr;
    logic [NB_DATA-1:0]  i_dbg_wdata;
    logic                i_dbg_rready;
    logic                o_dbg_ack;
    logic                o_dbg_rvalid;
    logic [NB_DATA-1:0]  o_dbg_rdata;
    logic [NB_DEPTH-1:0] o_dbg_raddr;
    logic                o_dbg_done;
    logic                o_dbg_busy;

    logic [NB_DEPTH-1:0] o_mem_addr;
    logic [NB_DATA-1:0]  o_mem_wdata;
    logic [1:0]          o_mem_we;
    logic [1:0]          o_mem_re;
    logic [NB_DATA-1:0]  i_mem_rdata;

    // Arbiter side
    modport slave (
        input  i_cpu_addr, i_cpu_wdata, i_cpu_we, i_cpu_re,
        output o_cpu_rdata, o_cpu_stall,
        input  i_dbg_req, i_dbg_op, i_dbg_addr, i_dbg_wdata, i_dbg_rready,
        output o_dbg_ack, o_dbg_rvalid, o_dbg_rdata, o_dbg_raddr, o_dbg_done, o_dbg_busy,
        output o_mem_addr, o_mem_wdata, o_mem_we, o_mem_re,
        input  i_mem_rdata
    );

    // CPU / debugger / memory side
    modport master (
        output i_cpu_addr, i_cpu_wdata, i_cpu_we, i_cpu_re,
        input  o_cpu_rdata, o_cpu_stall,
        output i_dbg_req, i_dbg_op, i_dbg_addr, i_dbg_wdata, i_dbg_rready,
        input  o_dbg_ack, o_dbg_rvalid, o_dbg_rdata, o_dbg_raddr, o_dbg_done, o_dbg_busy,
        input  o_mem_addr, o_mem_wdata, o_mem_we, o_mem_re,
        output i_mem_rdata
    );
endinterface

`default_nettype wire

// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_arbiter
// Brief    : Shares one data memory between a CPU port (priority) and a debug
//            port offering word read, word write and full-memory dump.
//            Optional macro DMEM_ARB_STARVE_GUARD_EN adds a starvation guard.
// Revision : 1.0  initial release
// ============================================================================

module data_mem_arbiter #(
    parameter int NB_DEPTH     = 8,
    parameter int NB_DATA      = 32,
    parameter int STARVE_LIMIT = 16
) (
    input  wire logic         i_clk,
    input  wire logic         i_rst_n,
    data_mem_arbiter_if.slave bus
);
    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] RD_WAIT    = 3'd1;
    localparam logic [2:0] RESP       = 3'd2;
    localparam logic [2:0] DUMP_ISSUE = 3'd3;
    localparam logic [2:0] DUMP_WAIT  = 3'd4;
    localparam logic [2:0] DUMP_RESP  = 3'd5;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_RD   = 2'b01;
    localparam logic [1:0] OP_WR   = 2'b10;
    localparam logic [1:0] OP_DUMP = 2'b11;

    localparam logic [NB_DEPTH-1:0] LAST_ADDR = '1;

    logic [2:0]          r_state;
    logic [2:0]          w_next;
    logic [NB_DEPTH-1:0] r_dump_cnt;
    logic [NB_DEPTH-1:0] r_issue_addr;
    logic [NB_DEPTH-1:0] r_raddr;
    logic [NB_DATA-1:0]  r_rdata;
    logic                r_done;

    logic w_cpu_active;
    logic w_idle_req;
    logic w_issue_pend;
    logic w_force;
    logic w_grant;
    logic w_accept;
    logic w_hs;

    // Debug logic is gated by reset so nothing reaches memory while held in reset
    assign w_cpu_active = (bus.i_cpu_we != `WRITE_DISABLE) || (bus.i_cpu_re != `READ_DISABLE);
    assign w_idle_req   = (r_state == IDLE) && bus.i_dbg_req;
    assign w_issue_pend = i_rst_n &&
                          ((w_idle_req && (bus.i_dbg_op == OP_RD || bus.i_dbg_op == OP_WR)) ||
                           (r_state == DUMP_ISSUE));
    assign w_grant      = w_issue_pend && (!w_cpu_active || w_force);
    assign w_accept     = i_rst_n && w_idle_req &&
                          (bus.i_dbg_op == OP_NOP || bus.i_dbg_op == OP_DUMP || w_grant);
    assign w_hs         = ((r_state == RESP) || (r_state == DUMP_RESP)) && bus.i_dbg_rready;

`ifdef DMEM_ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic [SW-1:0] r_starve_cnt;

    // Counts consecutive cycles a debug issue loses to the CPU
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_starve_cnt <= '0;
        end else if (w_grant || !w_issue_pend) begin
            r_starve_cnt <= '0;
        end else if (r_starve_cnt != STARVE_MAX) begin
            r_starve_cnt <= r_starve_cnt + SW'(1);
        end
    end

    assign w_force         = w_issue_pend && (r_starve_cnt == STARVE_MAX);
    assign bus.o_cpu_stall = w_force && w_cpu_active;
`else
    assign w_force         = 1'b0;
    assign bus.o_cpu_stall = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    case (bus.i_dbg_op)
                        OP_RD:   w_next = RD_WAIT;
                        OP_DUMP: w_next = DUMP_ISSUE;
                        default: w_next = IDLE;
                    endcase
                end
            end
            RD_WAIT:    w_next = RESP;
            RESP:       if (bus.i_dbg_rready) w_next = IDLE;
            DUMP_ISSUE: if (w_grant) w_next = DUMP_WAIT;
            DUMP_WAIT:  w_next = DUMP_RESP;
            DUMP_RESP: begin
                if (bus.i_dbg_rready) begin
                    w_next = (r_dump_cnt == LAST_ADDR) ? IDLE : DUMP_ISSUE;
                end
            end
            default:    w_next = IDLE;
        endcase
    end

    always_comb begin
        bus.o_mem_addr  = bus.i_cpu_addr;
        bus.o_mem_wdata = bus.i_cpu_wdata;
        bus.o_mem_we    = bus.i_cpu_we;
        bus.o_mem_re    = bus.i_cpu_re;
        if (w_grant) begin
            bus.o_mem_wdata = bus.i_dbg_wdata;
            bus.o_mem_we    = `WRITE_DISABLE;
            bus.o_mem_re    = `READ_DISABLE;
            if (r_state == DUMP_ISSUE) begin
                bus.o_mem_addr = r_dump_cnt;
                bus.o_mem_re   = `READ_WORD;
            end else begin
                bus.o_mem_addr = bus.i_dbg_addr;
                if (bus.i_dbg_op == OP_WR) begin
                    bus.o_mem_we = `WRITE_WORD;
                end else begin
                    bus.o_mem_re = `READ_WORD;
                end
            end
        end
    end

    assign bus.o_cpu_rdata  = bus.i_mem_rdata;
    assign bus.o_dbg_ack    = w_accept;
    assign bus.o_dbg_busy   = (r_state != IDLE);
    assign bus.o_dbg_rvalid = (r_state == RESP) || (r_state == DUMP_RESP);
    assign bus.o_dbg_rdata  = r_rdata;
    assign bus.o_dbg_raddr  = r_raddr;
    assign bus.o_dbg_done   = r_done;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_done       <= 1'b0;
            r_dump_cnt   <= '0;
            r_issue_addr <= '0;
            r_raddr      <= '0;
            r_rdata      <= '0;
        end else begin
            r_done <= (w_accept && (bus.i_dbg_op == OP_WR || bus.i_dbg_op == OP_NOP)) ||
                      (w_hs && ((r_state == RESP) || (r_dump_cnt == LAST_ADDR)));
            if (w_accept && bus.i_dbg_op == OP_DUMP) begin
                r_dump_cnt <= '0;
            end else if (w_hs && r_state == DUMP_RESP && r_dump_cnt != LAST_ADDR) begin
                r_dump_cnt <= r_dump_cnt + 1'b1;
            end
            if (w_grant) begin
                r_issue_addr <= (r_state == DUMP_ISSUE) ? r_dump_cnt : bus.i_dbg_addr;
            end
            // Memory read data is valid the cycle after issue
            if (r_state == RD_WAIT || r_state == DUMP_WAIT) begin
                r_rdata <= bus.i_mem_rdata;
                r_raddr <= r_issue_addr;
            end
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_arbiter
// Brief    : Directed self-checking bench for data_mem_arbiter (NB_DEPTH=3).
// Revision : 1.0  initial release
// ============================================================================

module tb_data_mem_arbiter;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    data_mem_arbiter_if #(.NB_DEPTH(3), .NB_DATA(32)) bus ();

    data_mem_arbiter #(.NB_DEPTH(3), .NB_DATA(32), .STARVE_LIMIT(4)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Registered memory model, one-cycle read latency
    logic [31:0] mem [8];
    always @(posedge clk) begin
        if (bus.o_mem_re != 2'b00) bus.i_mem_rdata <= mem[bus.o_mem_addr];
        case (bus.o_mem_we)
            2'b11:   mem[bus.o_mem_addr]        <= bus.o_mem_wdata;
            2'b10:   mem[bus.o_mem_addr][15:0]  <= bus.o_mem_wdata[15:0];
            2'b01:   mem[bus.o_mem_addr][7:0]   <= bus.o_mem_wdata[7:0];
            default: ;
        endcase
    end

    task automatic test_reset();
        rst_n = 1'b0;
        bus.i_dbg_req = 1'b1; bus.i_dbg_op = 2'b01; bus.i_dbg_addr = 3'd5;
        bus.i_cpu_re = 2'b11; bus.i_cpu_addr = 3'd3;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (bus.o_dbg_ack !== 1'b0) $display("FAIL rst_ack: got %b want 0", bus.o_dbg_ack); else n_pass++;
        n_checks++; if (bus.o_dbg_busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus.o_dbg_busy); else n_pass++;
        n_checks++; if (bus.o_dbg_rvalid !== 1'b0) $display("FAIL rst_rvalid: got %b want 0", bus.o_dbg_rvalid); else n_pass++;
        n_checks++; if (bus.o_dbg_done !== 1'b0) $display("FAIL rst_done: got %b want 0", bus.o_dbg_done); else n_pass++;
        n_checks++; if (bus.o_cpu_stall !== 1'b0) $display("FAIL rst_stall: got %b want 0", bus.o_cpu_stall); else n_pass++;
        n_checks++; if (bus.o_dbg_rdata !== 32'h0) $display("FAIL rst_rdata: got %h want 0", bus.o_dbg_rdata); else n_pass++;
        n_checks++; if (bus.o_dbg_raddr !== 3'd0) $display("FAIL rst_raddr: got %h want 0", bus.o_dbg_raddr); else n_pass++;
        n_checks++; if (bus.o_mem_re !== 2'b11 || bus.o_mem_addr !== 3'd3)
            $display("FAIL rst_mem_follows_cpu: got re=%b addr=%h want re=11 addr=3", bus.o_mem_re, bus.o_mem_addr); else n_pass++;
        @(negedge clk);
        bus.i_dbg_req = 1'b0; bus.i_cpu_re = 2'b00;
        rst_n = 1'b1;
    endtask

    task automatic test_dbg_write_read();
        @(negedge clk);
        bus.i_dbg_req = 1'b1; bus.i_dbg_op = 2'b10; bus.i_dbg_addr = 3'd5; bus.i_dbg_wdata = 32'hDEADBEEF;
        #1;
        n_checks++; if (bus.o_dbg_ack !== 1'b1) $display("FAIL wr_ack: got %b want 1", bus.o_dbg_ack); else n_pass++;
        n_checks++; if (bus.o_mem_we !== 2'b11 || bus.o_mem_addr !== 3'd5 || bus.o_mem_wdata !== 32'hDEADBEEF)
            $display("FAIL wr_issue: got we=%b addr=%h data=%h want 11/5/deadbeef", bus.o_mem_we, bus.o_mem_addr, bus.o_mem_wdata); else n_pass++;
        @(negedge clk);
        bus.i_dbg_req = 1'b0;
        #1;
        n_checks++; if (bus.o_dbg_done !== 1'b1 || bus.o_dbg_busy !== 1'b0)
            $display("FAIL wr_done: got done=%b busy=%b want 1/0", bus.o_dbg_done, bus.o_dbg_busy); else n_pass++;
        @(negedge clk);
        bus.i_dbg_req = 1'b1; bus.i_dbg_op = 2'b01; bus.i_dbg_addr = 3'd5;
        #1;
        n_checks++; if (bus.o_dbg_ack !== 1'b1 || bus.o_mem_re !== 2'b11)
            $display("FAIL rd_ack: got ack=%b re=%b want 1/11", bus.o_dbg_ack, bus.o_mem_re); else n_pass++;
        n_checks++; if (bus.o_dbg_done !== 1'b0) $display("FAIL wr_done_pulse: got %b want 0", bus.o_dbg_done); else n_pass++;
        @(negedge clk);
        bus.i_dbg_req = 1'b0;
        #1;
        n_checks++; if (bus.o_dbg_rvalid !== 1'b0 || bus.o_dbg_busy !== 1'b1)
            $display("FAIL rd_wait: got rvalid=%b busy=%b want 0/1", bus.o_dbg_rvalid, bus.o_dbg_busy); else n_pass++;
        @(negedge clk);
        #1;
        n_checks++; if (bus.o_dbg_rvalid !== 1'b1 || bus.o_dbg_rdata !== 32'hDEADBEEF || bus.o_dbg_raddr !== 3'd5)
            $display("FAIL rd_resp: got v=%b d=%h a=%h want 1/deadbeef/5", bus.o_dbg_rvalid, bus.o_dbg_rdata, bus.o_dbg_raddr); else n_pass++;
        @(negedge clk);
        bus.i_dbg_rready = 1'b1;
        #1;
        n_checks++; if (bus.o_dbg_rvalid !== 1'b1 || bus.o_dbg_rdata !== 32'hDEADBEEF)
            $display("FAIL rd_hold: got v=%b d=%h want 1/deadbeef", bus.o_dbg_rvalid, bus.o_dbg_rdata); else n_pass++;
        @(negedge clk);
        bus.i_dbg_rready = 1'b0;
        #1;
        n_checks++; if (bus.o_dbg_rvalid !== 1'b0 || bus.o_dbg_done !== 1'b1)
            $display("FAIL rd_done: got v=%b done=%b want 0/1", bus.o_dbg_rvalid, bus.o_dbg_done); else n_pass++;
    endtask

    task automatic test_cpu_priority();
        @(negedge clk);
        bus.i_cpu_we = 2'b11; bus.i_cpu_addr = 3'd6; bus.i_cpu_wdata = 32'h12345678;
        #1;
        n_checks++; if (bus.o_mem_we !== 2'b11 || bus.o_mem_wdata !== 32'h12345678)
            $display("FAIL cpu_wr: got we=%b d=%h want 11/12345678", bus.o_mem_we, bus.o_mem_wdata); else n_pass++;
        @(negedge clk);
        bus.i_cpu_we = 2'b00; bus.i_cpu_re = 2'b11; bus.i_cpu_addr = 3'd5;
        bus.i_dbg_req = 1'b1; bus.i_dbg_op = 2'b01; bus.i_dbg_addr = 3'd6;
        #1;
        n_checks++; if (bus.o_mem_addr !== 3'd5 || bus.o_mem_re !== 2'b11 || bus.o_dbg_ack !== 1'b0)
            $display("FAIL prio_cpu_wins: got addr=%h re=%b ack=%b want 5/11/0", bus.o_mem_addr, bus.o_mem_re, bus.o_dbg_ack); else n_pass++;
        @(negedge clk);
        bus.i_cpu_re = 2'b00;
        #1;
        n_checks++; if (bus.o_cpu_rdata !== 32'hDEADBEEF)
            $display("FAIL prio_cpu_rdata: got %h want deadbeef", bus.o_cpu_rdata); else n_pass++;
        n_checks++; if (bus.o_dbg_ack !== 1'b1 || bus.o_mem_addr !== 3'd6)
            $display("FAIL prio_dbg_late_ack: got ack=%b addr=%h want 1/6", bus.o_dbg_ack, bus.o_mem_addr); else n_pass++;
        @(negedge clk);
        bus.i_dbg_req = 1'b0;
        @(negedge clk);
        bus.i_dbg_rready = 1'b1;
        #1;
        n_checks++; if (bus.o_dbg_rvalid !== 1'b1 || bus.o_dbg_rdata !== 32'h12345678 || bus.o_dbg_raddr !== 3'd6)
            $display("FAIL prio_dbg_resp: got v=%b d=%h a=%h want 1/12345678/6", bus.o_dbg_rvalid, bus.o_dbg_rdata, bus.o_dbg_raddr); else n_pass++;
        @(negedge clk);
        bus.i_dbg_rready = 1'b0;
    endtask

    task automatic test_dump();
        int  hs;
        bit  tog;
        bit  done_seen;
        logic [2:0] last_a;
        logic [2:0] exp_a;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.i_cpu_we = 2'b11; bus.i_cpu_addr = 3'(i); bus.i_cpu_wdata = 32'(i * 17);
        end
        @(negedge clk);
        bus.i_cpu_we = 2'b00;
        bus.i_dbg_req = 1'b1; bus.i_dbg_op = 2'b11; bus.i_dbg_addr = 3'd5;
        #1;
        n_checks++; if (bus.o_dbg_ack !== 1'b1 || bus.o_mem_re !== 2'b00)
            $display("FAIL dump_ack: got ack=%b re=%b want 1/00", bus.o_dbg_ack, bus.o_mem_re); else n_pass++;
        @(negedge clk);
        bus.i_dbg_req = 1'b0;
        #1;
        n_checks++; if (bus.o_mem_re !== 2'b11 || bus.o_mem_addr !== 3'd0 || bus.o_dbg_busy !== 1'b1)
            $display("FAIL dump_first_issue: got re=%b addr=%h busy=%b want 11/0/1", bus.o_mem_re, bus.o_mem_addr, bus.o_dbg_busy); else n_pass++;
        hs = 0; tog = 1'b1; done_seen = 1'b0; last_a = 3'd0;
        for (int c = 0; c < 100 && !done_seen; c++) begin
            @(negedge clk);
            bus.i_dbg_rready = tog;
            tog = ~tog;
            #1;
            if (bus.o_dbg_done) done_seen = 1'b1;
            if (bus.o_dbg_rvalid && bus.i_dbg_rready) begin
                exp_a = 3'(hs);
                n_checks++; if (bus.o_dbg_raddr !== exp_a)
                    $display("FAIL dump_raddr: got %h want %h", bus.o_dbg_raddr, exp_a); else n_pass++;
                n_checks++; if (bus.o_dbg_rdata !== 32'(hs * 17))
                    $display("FAIL dump_rdata: got %h want %h", bus.o_dbg_rdata, 32'(hs * 17)); else n_pass++;
                last_a = bus.o_dbg_raddr;
                hs++;
            end
        end
        n_checks++; if (done_seen !== 1'b1 || hs != 8 || last_a !== 3'd7)
            $display("FAIL dump_complete: got done=%b hs=%0d last=%h want 1/8/7", done_seen, hs, last_a); else n_pass++;
        @(negedge clk);
        bus.i_dbg_rready = 1'b0;
        #1;
        n_checks++; if (bus.o_dbg_rvalid !== 1'b0 || bus.o_dbg_busy !== 1'b0 || bus.o_dbg_done !== 1'b0)
            $display("FAIL dump_no_wrap: got v=%b busy=%b done=%b want 0/0/0", bus.o_dbg_rvalid, bus.o_dbg_busy, bus.o_dbg_done); else n_pass++;
    endtask

    task automatic test_reset_mid_dump();
        bit found;
        bit done_seen;
        @(negedge clk);
        bus.i_dbg_req = 1'b1; bus.i_dbg_op = 2'b11;
        @(negedge clk);
        bus.i_dbg_req = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 60 && !found; c++) begin
            @(negedge clk);
            #1;
            if (bus.o_dbg_rvalid && bus.o_dbg_raddr == 3'd3) found = 1'b1;
            else bus.i_dbg_rready = bus.o_dbg_rvalid;
        end
        bus.i_dbg_rready = 1'b0;
        n_checks++; if (found !== 1'b1) $display("FAIL rstdump_reach3: got %b want 1", found); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.o_dbg_rvalid !== 1'b0 || bus.o_dbg_busy !== 1'b0)
            $display("FAIL rstdump_drop: got v=%b busy=%b want 0/0", bus.o_dbg_rvalid, bus.o_dbg_busy); else n_pass++;
        n_checks++; if (bus.o_dbg_raddr !== 3'd0 || bus.o_dbg_rdata !== 32'h0)
            $display("FAIL rstdump_clear: got a=%h d=%h want 0/0", bus.o_dbg_raddr, bus.o_dbg_rdata); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++; if (bus.o_dbg_busy !== 1'b0) $display("FAIL rstdump_idle: got busy=%b want 0", bus.o_dbg_busy); else n_pass++;
        @(negedge clk);
        bus.i_dbg_req = 1'b1; bus.i_dbg_op = 2'b11;
        #1;
        n_checks++; if (bus.o_dbg_ack !== 1'b1) $display("FAIL rstdump_reack: got %b want 1", bus.o_dbg_ack); else n_pass++;
        @(negedge clk);
        bus.i_dbg_req = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            #1;
            if (bus.o_dbg_rvalid) found = 1'b1;
        end
        n_checks++; if (found !== 1'b1 || bus.o_dbg_raddr !== 3'd0 || bus.o_dbg_rdata !== 32'h0)
            $display("FAIL rstdump_restart: got v=%b a=%h d=%h want 1/0/0", found, bus.o_dbg_raddr, bus.o_dbg_rdata); else n_pass++;
        bus.i_dbg_rready = 1'b1;
        done_seen = 1'b0;
        for (int c = 0; c < 100 && !done_seen; c++) begin
            @(negedge clk);
            #1;
            if (bus.o_dbg_done) done_seen = 1'b1;
        end
        bus.i_dbg_rready = 1'b0;
        n_checks++; if (done_seen !== 1'b1) $display("FAIL rstdump_finish: got done=%b want 1", done_seen); else n_pass++;
    endtask

    task automatic test_starve();
        bit acked;
        bit exp_hit;
        bit done_seen;
        bit guard;
`ifdef DMEM_ARB_STARVE_GUARD_EN
        guard = 1'b1;
`else
        guard = 1'b0;
`endif
        acked = 1'b0;
        @(negedge clk);
        bus.i_cpu_re = 2'b11; bus.i_cpu_addr = 3'd1;
        bus.i_dbg_req = 1'b1; bus.i_dbg_op = 2'b01; bus.i_dbg_addr = 3'd2;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk);
            if (acked) bus.i_dbg_req = 1'b0;
            #1;
            exp_hit = guard && (c == 4);
            n_checks++; if (bus.o_dbg_ack !== exp_hit || bus.o_cpu_stall !== exp_hit)
                $display("FAIL starve_cycle%0d: got ack=%b stall=%b want %b/%b", c, bus.o_dbg_ack, bus.o_cpu_stall, exp_hit, exp_hit); else n_pass++;
            if (bus.o_dbg_ack) begin
                acked = 1'b1;
                n_checks++; if (bus.o_mem_addr !== 3'd2 || bus.o_mem_re !== 2'b11)
                    $display("FAIL starve_forced_issue: got addr=%h re=%b want 2/11", bus.o_mem_addr, bus.o_mem_re); else n_pass++;
            end
        end
        done_seen = 1'b0;
        for (int c = 0; c < 20 && !done_seen; c++) begin
            @(negedge clk);
            bus.i_cpu_re = 2'b00;
            if (acked) bus.i_dbg_req = 1'b0;
            #1;
            if (bus.o_dbg_ack) acked = 1'b1;
            if (bus.o_dbg_done) done_seen = 1'b1;
            if (bus.o_dbg_rvalid && !bus.i_dbg_rready) begin
                bus.i_dbg_rready = 1'b1;
                n_checks++; if (bus.o_dbg_rdata !== 32'h22)
                    $display("FAIL starve_rdata: got %h want 00000022", bus.o_dbg_rdata); else n_pass++;
            end
        end
        bus.i_dbg_rready = 1'b0;
        n_checks++; if (done_seen !== 1'b1) $display("FAIL starve_finish: got done=%b want 1", done_seen); else n_pass++;
    endtask

    initial begin
        bus.i_cpu_addr = '0; bus.i_cpu_wdata = '0; bus.i_cpu_we = 2'b00; bus.i_cpu_re = 2'b00;
        bus.i_dbg_req = 1'b0; bus.i_dbg_op = 2'b00; bus.i_dbg_addr = '0; bus.i_dbg_wdata = '0;
        bus.i_dbg_rready = 1'b0;
        test_reset();
        test_dbg_write_read();
        test_cpu_priority();
        test_dump();
        test_reset_mid_dump();
        test_starve();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", n_pass, n_checks);
        $fatal(1);
    end
endmodule

`default_nettype wire

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 SHALL have parameter NB_DEPTH, default 8, giving the address width; memory holds 2**NB_DEPTH words.
REQ-002 SHALL have parameter NB_DATA, default 32, giving the word width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 16, giving the debug-blocked cycle count before a forced grant.
REQ-004 SHALL have i_clk, input, 1, the single clock; all logic is rising-edge.
REQ-005 SHALL have i_rst_n, input, 1, reset: asynchronous, active-low.
REQ-006 SHALL have CPU port inputs: i_cpu_addr [NB_DEPTH], i_cpu_wdata [NB_DATA], i_cpu_we [2], i_cpu_re [2]; encodings are the `WRITE_*/`READ_* codes (00 disable, 01 byte, 10 halfword, 11 word).
REQ-007 SHALL have o_cpu_rdata [NB_DATA], the memory read data passed to the CPU, and o_cpu_stall [1], the forced-wait request to the CPU.
REQ-008 SHALL have debug inputs: i_dbg_req [1], i_dbg_op [2] (01 read, 10 write, 11 dump, 00 reserved), i_dbg_addr [NB_DEPTH], i_dbg_wdata [NB_DATA], i_dbg_rready [1].
REQ-009 SHALL have debug outputs: o_dbg_ack [1], o_dbg_rvalid [1], o_dbg_rdata [NB_DATA], o_dbg_raddr [NB_DEPTH], o_dbg_done [1], o_dbg_busy [1].
REQ-010 SHALL have memory-side outputs: o_mem_addr [NB_DEPTH], o_mem_wdata [NB_DATA], o_mem_we [2], o_mem_re [2]; and input i_mem_rdata [NB_DATA] (memory output, registered, 1-cycle read latency).

Function
REQ-011 SHALL drive the memory from the CPU port combinationally whenever i_cpu_we or i_cpu_re is nonzero and no forced grant is active (CPU priority).
REQ-012 SHALL drive o_cpu_rdata = i_mem_rdata at all times.
REQ-013 SHALL use FSM states IDLE, RD_WAIT, RESP, DUMP_ISSUE, DUMP_WAIT, DUMP_RESP.
REQ-014 SHALL, in IDLE with i_dbg_req=1 and a free memory cycle, accept the op: pulse o_dbg_ack for one cycle and issue the access in that same cycle.
REQ-015 SHALL issue debug accesses as word only (we or re = 11); idle memory cycles drive we=re=00.
REQ-016 SHALL hold a blocked request pending without ack; the requester holds i_dbg_req/op/addr/wdata until ack.
REQ-017 Write: issue with we=11 and return to IDLE; o_dbg_done pulses the cycle after issue.
REQ-018 Read: issue with re=11 -> RD_WAIT; capture i_mem_rdata into o_dbg_rdata and the address into o_dbg_raddr; -> RESP with o_dbg_rvalid=1 two cycles after ack.
REQ-019 SHALL hold o_dbg_rvalid, o_dbg_rdata and o_dbg_raddr stable until i_dbg_rready=1, then return to IDLE with o_dbg_done pulsed for one cycle.
REQ-020 Dump: reset the internal counter to 0, then for each address issue a word read (DUMP_ISSUE, when memory is free) -> DUMP_WAIT capture -> DUMP_RESP valid/ready handshake; i_dbg_addr is ignored.
REQ-021 SHALL advance the dump counter only on a handshake; after address 2**NB_DEPTH-1 SHALL not wrap, but pulse o_dbg_done and return to IDLE.
REQ-022 SHALL treat op 00 as a no-op: ack, done pulse, stay IDLE.
REQ-023 SHALL assert o_dbg_busy in every state except IDLE.
REQ-024 On a simultaneous CPU access and debug issue, the CPU SHALL win and the debug issue retries on the next free cycle; this also applies mid-dump.

Reset
REQ-025 SHALL, with i_rst_n=0, immediately set the state to IDLE, the counters to 0, and o_dbg_ack/rvalid/done/busy, o_cpu_stall, o_dbg_rdata and o_dbg_raddr to 0, aborting any in-flight op; the memory-side outputs follow the CPU port.

Configuration
REQ-026 With macro DMEM_ARB_STARVE_GUARD_EN defined: count consecutive cycles with a debug issue pending but blocked; on reaching STARVE_LIMIT, assert o_cpu_stall for one cycle and give that memory cycle to debug; the CPU holds its access; the counter clears on any debug issue.
REQ-027 Without DMEM_ARB_STARVE_GUARD_EN: o_cpu_stall is tied 0, no counter exists, and debug waits indefinitely.

Verification
REQ-028 CPU idle, dbg write op=10 addr=0x05 data=0xDEADBEEF -> ack cycle 0, done cycle 1; then dbg read addr=0x05 -> rvalid cycle 2, rdata=0xDEADBEEF, raddr=0x05.
REQ-029 CPU word read addr=0x05 with a simultaneous dbg read addr=0x06 -> memory sees the CPU access, o_cpu_rdata=0xDEADBEEF the next cycle; dbg ack is delayed to the first idle CPU cycle.
REQ-030 Dump with NB_DEPTH=3, mem[i]=i*0x11, rready toggling 1/0 -> 8 handshakes, raddr 0..7, rdata 0x00..0x77, done after raddr=7, no wrap.
REQ-031 i_rst_n=0 during RESP of a dump at raddr=3 -> rvalid and busy drop at once; after release, state is IDLE and a new dump starts at raddr=0.
REQ-032 DMEM_ARB_STARVE_GUARD_EN, STARVE_LIMIT=4, CPU accessing every cycle, dbg read pending -> o_cpu_stall pulses one cycle after 4 blocked cycles; ack occurs in that cycle; without the macro, no ack and stall stays 0.
